// File: rtl/sort_dedup_sequencer_if.sv
// Stream-side bundle of the sort/dedup sequencer: sample input, unique-value output, status.
interface sort_dedup_sequencer_if #(
   parameter int unsigned W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic [3:0]   out_count;
   logic         busy;

   // Producer/consumer side
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_count, busy
   );

   // Sequencer side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, out_count, busy
   );
endinterface

// File: rtl/sort_dedup_sequencer.sv
// Collects N samples, sorts them with odd-even transposition (one phase per cycle),
// compacts duplicates in place (one element per cycle), then streams unique values out.
module sort_dedup_sequencer #(
   parameter int unsigned N = 9,
   parameter int unsigned W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   sort_dedup_sequencer_if.slave bus
);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {LOAD, SORT, DEDUP, EMIT} state_e;

   state_e         state_q,     state_d;
   logic [W-1:0]   mem_q [N];
   logic [W-1:0]   mem_d [N];
   logic [CW-1:0]  ld_q,        ld_d;
   logic [CW-1:0]  pass_q,      pass_d;
   logic [CW-1:0]  scan_q,      scan_d;
   logic [CW-1:0]  wr_q,        wr_d;
   logic [CW-1:0]  rd_q,        rd_d;
   logic [CW-1:0]  out_count_q, out_count_d;
   logic [W-1:0]   out_data_q,  out_data_d;
   logic           out_valid_q, out_valid_d;
   logic           out_last_q,  out_last_d;
   logic           in_ready_q,  in_ready_d;
   logic           busy_q,      busy_d;
   logic [CW-1:0]  wr_m1;
   logic [CW-1:0]  wr_next;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_count = out_count_q;
   assign bus.busy      = busy_q;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      ld_d        = ld_q;
      pass_d      = pass_q;
      scan_d      = scan_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      out_count_d = out_count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      wr_m1       = wr_q - CW'(1);
      wr_next     = wr_q;

      case (state_q)
         LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               mem_d[ld_q] = bus.in_data;
               if (ld_q == CW'(N - 1)) begin
                  ld_d    = '0;
                  pass_d  = '0;
                  state_d = SORT;
               end else begin
                  ld_d = ld_q + CW'(1);
               end
            end
         end

         SORT: begin
            // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)...
            for (int unsigned k = 0; k < N - 1; k++) begin
               if (k[0] == pass_q[0] && mem_q[k] > mem_q[k+1]) begin
                  mem_d[k]   = mem_q[k+1];
                  mem_d[k+1] = mem_q[k];
               end
            end
            if (pass_q == CW'(N - 1)) begin
               scan_d  = CW'(1);
               wr_d    = CW'(1);
               state_d = DEDUP;
            end else begin
               pass_d = pass_q + CW'(1);
            end
         end

         DEDUP: begin
            // Write pointer never passes the scan pointer, so in-place compaction is safe
            if (mem_q[scan_q] != mem_q[wr_m1]) begin
               mem_d[wr_q] = mem_q[scan_q];
               wr_next     = wr_q + CW'(1);
            end
            wr_d = wr_next;
            if (scan_q == CW'(N - 1)) begin
               out_count_d = wr_next;
               rd_d        = '0;
               out_valid_d = 1'b1;
               out_data_d  = mem_q[0];
               out_last_d  = (wr_next == CW'(1));
               state_d     = EMIT;
            end else begin
               scan_d = scan_q + CW'(1);
            end
         end

         EMIT: begin
            if (bus.out_ready && out_valid_q) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  rd_d        = '0;
                  state_d     = LOAD;
               end else begin
                  rd_d       = rd_q + CW'(1);
                  out_data_d = mem_q[rd_d];
                  out_last_d = (rd_d == out_count_q - CW'(1));
               end
            end
         end

         default: state_d = LOAD;
      endcase

      in_ready_d = (state_d == LOAD);
      busy_d     = (state_d != LOAD);
   end

   // State and output registers with synchronous reset; sample buffer is not reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         state_q     <= LOAD;
         ld_q        <= '0;
         pass_q      <= '0;
         scan_q      <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         out_count_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_q        <= ld_d;
         pass_q      <= pass_d;
         scan_q      <= scan_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         out_count_q <= out_count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end
endmodule

// File: tb/tb_sort_dedup_sequencer.sv
// Directed bench for sort_dedup_sequencer: frames with hand-computed unique outputs.
module tb_sort_dedup_sequencer;
   localparam int unsigned N = 9;
   localparam int unsigned W = 8;

   typedef logic [W-1:0] frame_t [N];
   typedef logic [W-1:0] dq_t [$];
   typedef logic         bq_t [$];
   typedef logic [3:0]   cq_t [$];

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   sort_dedup_sequencer_if #(.W(W)) bus ();

   sort_dedup_sequencer #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Offer one frame, with optional random idle gaps; ok=0 if a sample is never accepted.
   task automatic load_frame(input frame_t f, input int max_gap, output int ok);
      int  gap;
      int  t;
      bit  acc;
      ok = 1;
      for (int i = 0; i < int'(N); i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hEE;
            @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = f[i];
         acc = 1'b0;
         t   = 0;
         while (!acc && t < 100) begin
            acc = bus.in_ready;
            @(negedge clk);
            t++;
         end
         if (!acc) begin
            ok = 0;
            bus.in_valid = 1'b0;
            return;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
   endtask

   // Drain one frame's output; stall applies the 1,0,0,1 ready pattern. Also counts
   // stall-stability violations and cycles with in_ready high while output is pending.
   task automatic collect(input bit stall, output dq_t d, output bq_t l, output cq_t c,
                          output int lat, output int stab_err);
      int           cyc;
      int           kv;
      bit           done;
      bit           prev_stall;
      logic [W-1:0] pd;
      logic         pl;
      logic [3:0]   pc;
      d = {}; l = {}; c = {};
      lat = -1; stab_err = 0; cyc = 0; kv = 0; done = 1'b0; prev_stall = 1'b0;
      pd = '0; pl = 1'b0; pc = '0;
      while (!done && cyc < 400) begin
         bus.out_ready = !stall || (kv % 4 == 0) || (kv % 4 == 3);
         if (bus.out_valid) begin
            if (lat < 0) lat = cyc;
            if (bus.in_ready) stab_err++;
            if (prev_stall && (bus.out_data !== pd || bus.out_last !== pl || bus.out_count !== pc))
               stab_err++;
            if (bus.out_ready) begin
               d.push_back(bus.out_data);
               l.push_back(bus.out_last);
               c.push_back(bus.out_count);
               if (bus.out_last) done = 1'b1;
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               pd = bus.out_data;
               pl = bus.out_last;
               pc = bus.out_count;
            end
            kv++;
         end
         if (done) bus.in_valid = 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
          bus.out_data !== 8'h00 || bus.out_count !== 4'd0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%h cnt=%0d busy=%b expected all 0",
                  bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.out_count, bus.busy);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: got rdy=%b busy=%b expected rdy=1 busy=0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_basic();
      frame_t f = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd3, 8'd7, 8'd1, 8'd0, 8'd9};
      dq_t e = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
      dq_t d; bq_t l; cq_t c; int lat, se, ok;
      load_frame(f, 0, ok);
      vectors++;
      if (ok !== 1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_load: got ok=%0d busy=%b rdy=%b expected ok=1 busy=1 rdy=0", ok, bus.busy, bus.in_ready);
      end
      collect(1'b0, d, l, c, lat, se);
      vectors++;
      if (d.size() !== e.size()) begin
         miscompares++;
         $display("FAIL basic_len: got %0d transfers expected %0d", d.size(), e.size());
      end
      for (int i = 0; i < e.size(); i++) begin
         vectors++;
         if (i >= d.size()) begin
            miscompares++;
            $display("FAIL basic_elem[%0d]: got none expected %0d", i, e[i]);
         end else if (d[i] !== e[i] || l[i] !== (i == e.size() - 1) || c[i] !== 4'(e.size())) begin
            miscompares++;
            $display("FAIL basic_elem[%0d]: got data=%0d last=%b cnt=%0d expected data=%0d last=%b cnt=%0d",
                     i, d[i], l[i], c[i], e[i], (i == e.size() - 1), e.size());
         end
      end
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d edges expected 17", lat);
      end
      vectors++;
      if (se !== 0) begin
         miscompares++;
         $display("FAIL basic_stability: got %0d violations expected 0", se);
      end
   endtask

   task automatic test_all_equal();
      frame_t f = '{default: 8'hAA};
      dq_t d; bq_t l; cq_t c; int lat, se, ok;
      load_frame(f, 0, ok);
      collect(1'b0, d, l, c, lat, se);
      vectors++;
      if (ok !== 1 || d.size() !== 1) begin
         miscompares++;
         $display("FAIL equal_len: got ok=%0d transfers=%0d expected ok=1 transfers=1", ok, d.size());
      end else if (d[0] !== 8'hAA || l[0] !== 1'b1 || c[0] !== 4'd1) begin
         miscompares++;
         $display("FAIL equal_elem: got data=%h last=%b cnt=%0d expected data=aa last=1 cnt=1", d[0], l[0], c[0]);
      end
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL equal_latency: got %0d edges expected 17", lat);
      end
   endtask

   task automatic test_descending();
      frame_t f = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248, 8'd247};
      dq_t d; bq_t l; cq_t c; int lat, se, ok;
      logic [W-1:0] ev;
      load_frame(f, 0, ok);
      collect(1'b0, d, l, c, lat, se);
      vectors++;
      if (ok !== 1 || d.size() !== 9) begin
         miscompares++;
         $display("FAIL desc_len: got ok=%0d transfers=%0d expected ok=1 transfers=9", ok, d.size());
      end
      for (int i = 0; i < 9; i++) begin
         ev = 8'(247 + i);
         vectors++;
         if (i >= d.size()) begin
            miscompares++;
            $display("FAIL desc_elem[%0d]: got none expected %0d", i, ev);
         end else if (d[i] !== ev || l[i] !== (i == 8) || c[i] !== 4'd9) begin
            miscompares++;
            $display("FAIL desc_elem[%0d]: got data=%0d last=%b cnt=%0d expected data=%0d last=%b cnt=9",
                     i, d[i], l[i], c[i], ev, (i == 8));
         end
      end
   endtask

   task automatic test_stall();
      frame_t f = '{8'd4, 8'd4, 8'd2, 8'd2, 8'd0, 8'd0, 8'd8, 8'd8, 8'd6};
      dq_t e = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8};
      dq_t d; bq_t l; cq_t c; int lat, se, ok;
      load_frame(f, 0, ok);
      // A producer pushing while the block is busy must be ignored
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      collect(1'b1, d, l, c, lat, se);
      vectors++;
      if (ok !== 1 || d.size() !== e.size()) begin
         miscompares++;
         $display("FAIL stall_len: got ok=%0d transfers=%0d expected ok=1 transfers=%0d", ok, d.size(), e.size());
      end
      for (int i = 0; i < e.size(); i++) begin
         vectors++;
         if (i >= d.size()) begin
            miscompares++;
            $display("FAIL stall_elem[%0d]: got none expected %0d", i, e[i]);
         end else if (d[i] !== e[i] || l[i] !== (i == e.size() - 1) || c[i] !== 4'(e.size())) begin
            miscompares++;
            $display("FAIL stall_elem[%0d]: got data=%0d last=%b cnt=%0d expected data=%0d last=%b cnt=%0d",
                     i, d[i], l[i], c[i], e[i], (i == e.size() - 1), e.size());
         end
      end
      vectors++;
      if (se !== 0) begin
         miscompares++;
         $display("FAIL stall_stability: got %0d violations expected 0", se);
      end
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_count !== 4'd5 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_after: got rdy=%b vld=%b cnt=%0d busy=%b expected rdy=1 vld=0 cnt=5 busy=0",
                  bus.in_ready, bus.out_valid, bus.out_count, bus.busy);
      end
   endtask

   task automatic test_reset_dedup();
      frame_t fa = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207, 8'd208};
      frame_t fb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      dq_t d; bq_t l; cq_t c; int lat, se, ok, seen;
      load_frame(fa, 0, ok);
      repeat (11) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_pre: got busy=%b vld=%b expected busy=1 vld=0", bus.busy, bus.out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_reset: got busy=%b vld=%b rdy=%b expected 0 0 0", bus.busy, bus.out_valid, bus.in_ready);
      end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++;
         $display("FAIL abort_quiet: got %0d valid cycles expected 0", seen);
      end
      load_frame(fb, 0, ok);
      collect(1'b0, d, l, c, lat, se);
      vectors++;
      if (ok !== 1 || d.size() !== 9) begin
         miscompares++;
         $display("FAIL abort_len: got ok=%0d transfers=%0d expected ok=1 transfers=9", ok, d.size());
      end
      for (int i = 0; i < 9; i++) begin
         vectors++;
         if (i >= d.size()) begin
            miscompares++;
            $display("FAIL abort_elem[%0d]: got none expected %0d", i, i + 1);
         end else if (d[i] !== 8'(i + 1) || l[i] !== (i == 8) || c[i] !== 4'd9) begin
            miscompares++;
            $display("FAIL abort_elem[%0d]: got data=%0d last=%b cnt=%0d expected data=%0d last=%b cnt=9",
                     i, d[i], l[i], c[i], i + 1, (i == 8));
         end
      end
   endtask

   task automatic test_back_to_back();
      frame_t fa = '{8'd10, 8'd20, 8'd10, 8'd30, 8'd20, 8'd40, 8'd50, 8'd40, 8'd60};
      frame_t fb = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0};
      dq_t ea = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
      dq_t eb = '{8'd0, 8'd3};
      dq_t d; bq_t l; cq_t c; int lat, se, ok;
      load_frame(fa, 3, ok);
      collect(1'b0, d, l, c, lat, se);
      vectors++;
      if (ok !== 1 || d.size() !== ea.size()) begin
         miscompares++;
         $display("FAIL b2b_a_len: got ok=%0d transfers=%0d expected ok=1 transfers=%0d", ok, d.size(), ea.size());
      end
      for (int i = 0; i < ea.size(); i++) begin
         vectors++;
         if (i >= d.size()) begin
            miscompares++;
            $display("FAIL b2b_a_elem[%0d]: got none expected %0d", i, ea[i]);
         end else if (d[i] !== ea[i] || l[i] !== (i == ea.size() - 1) || c[i] !== 4'(ea.size())) begin
            miscompares++;
            $display("FAIL b2b_a_elem[%0d]: got data=%0d last=%b cnt=%0d expected data=%0d last=%b cnt=%0d",
                     i, d[i], l[i], c[i], ea[i], (i == ea.size() - 1), ea.size());
         end
      end
      load_frame(fb, 3, ok);
      collect(1'b0, d, l, c, lat, se);
      vectors++;
      if (ok !== 1 || d.size() !== eb.size()) begin
         miscompares++;
         $display("FAIL b2b_b_len: got ok=%0d transfers=%0d expected ok=1 transfers=%0d", ok, d.size(), eb.size());
      end
      for (int i = 0; i < eb.size(); i++) begin
         vectors++;
         if (i >= d.size()) begin
            miscompares++;
            $display("FAIL b2b_b_elem[%0d]: got none expected %0d", i, eb[i]);
         end else if (d[i] !== eb[i] || l[i] !== (i == eb.size() - 1) || c[i] !== 4'(eb.size())) begin
            miscompares++;
            $display("FAIL b2b_b_elem[%0d]: got data=%0d last=%b cnt=%0d expected data=%0d last=%b cnt=%0d",
                     i, d[i], l[i], c[i], eb[i], (i == eb.size() - 1), eb.size());
         end
      end
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL b2b_latency: got %0d edges expected 17", lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_equal();
      test_descending();
      test_stall();
      test_reset_dedup();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
